// File: rtl/oram_path_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oramPkg
//  Description : Shared Path ORAM geometry, tuple field offsets, writer FSM
//                state type and the path / placement helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package oramPkg;

    localparam int D        = 6;                 // tree depth (levels 0..D-1)
    localparam int K        = 3;                 // tuples per bucket
    localparam int A        = 8;                 // bytes per block value
    localparam int S        = 8;                 // stash entries

    localparam int TUPLE_W  = 2*D + 8*A + 2;
    localparam int POS_W    = D - 1;
    localparam int LVL_W    = $clog2(D);
    localparam int IDX_W    = $clog2(S);
    localparam int CNT_W    = $clog2(S + 1);
    localparam int FILL_W   = $clog2(K + 1);
    localparam int ADDR_W   = D + 1;
    localparam int BUCKET_W = K * TUPLE_W;

    // Tuple field offsets, LSB first
    localparam int VALID_OFF     = 0;
    localparam int VAL_VALID_OFF = 1;
    localparam int VAL_OFF       = 2;
    localparam int BNUM_OFF      = VAL_OFF + 8*A;
    localparam int POS_VALID_OFF = BNUM_OFF + D;
    localparam int POS_OFF       = POS_VALID_OFF + 1;

    typedef logic [TUPLE_W-1:0] tuple_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_t;

    // Heap node reached from the root by following leaf bits LSB first
    function automatic logic [D-1:0] node_on_path(input logic [POS_W-1:0] leaf,
                                                  input logic [LVL_W-1:0] level);
        logic [D-1:0] node;
        node = D'(1);
        for (int i = 0; i < POS_W; i++) begin
            if (i < int'(level)) begin
                node = {node[D-2:0], leaf[i]};
            end
        end
        return node;
    endfunction

    // A tuple may live at `level` when its leaf shares the low `level` path bits
    function automatic logic eligible(input tuple_t                t,
                                      input logic [POS_W-1:0]  leaf,
                                      input logic [LVL_W-1:0]  level);
        logic [POS_W-1:0] diff;
        logic             ok;
        diff = t[POS_OFF +: POS_W] ^ leaf;
        ok   = t[POS_VALID_OFF];
        for (int i = 0; i < POS_W; i++) begin
            if (i < int'(level) && diff[i]) begin
                ok = 1'b0;
            end
        end
        if (level == '0) begin
            ok = 1'b1;
        end
        return t[VALID_OFF] && ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oram_path_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : oram_path_writer_if
//  Description : Stash load, eviction control and bucket write bus of the
//                path writer. The slave modport is the writer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface oram_path_writer_if;
    import oramPkg::*;

    logic                in_valid;
    logic                in_ready;
    tuple_t              in_tuple;
    logic                start;
    logic [POS_W-1:0]    leaf;
    logic                busy;
    logic                done;
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [BUCKET_W-1:0] wr_bucket;
    logic [CNT_W-1:0]    stash_count;

    modport master (
        output in_valid, in_tuple, start, leaf, wr_ready,
        input  in_ready, busy, done, wr_valid, wr_addr, wr_bucket, stash_count
    );

    modport slave (
        input  in_valid, in_tuple, start, leaf, wr_ready,
        output in_ready, busy, done, wr_valid, wr_addr, wr_bucket, stash_count
    );

endinterface
`default_nettype wire

// File: rtl/oram_path_writer_stash.sv
`default_nettype none
// ============================================================================
//  Module      : oram_stash
//  Description : S-entry tuple stash. Inserts go to the lowest free entry,
//                reads and removals are by index; occupancy is derived from
//                the registered entry valid bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module oram_stash
    import oramPkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             ins_en,
    input  wire tuple_t           ins_tuple,
    input  wire logic [IDX_W-1:0] rd_idx,
    output tuple_t                rd_tuple,
    input  wire logic             rm_en,
    input  wire logic [IDX_W-1:0] rm_idx,
    output logic [CNT_W-1:0]      count,
    output logic                  full
);

    tuple_t entry_q [S];
    tuple_t entry_d [S];
    logic   placed;

    // Next entry contents: removal clears an entry, insert fills lowest free one
    always_comb begin
        entry_d = entry_q;
        placed  = 1'b0;
        if (rm_en) begin
            entry_d[rm_idx] = '0;
        end
        if (ins_en) begin
            for (int i = 0; i < S; i++) begin
                if (!placed && !entry_q[i][VALID_OFF]) begin
                    entry_d[i] = ins_tuple;
                    placed     = 1'b1;
                end
            end
        end
    end

    // Entry storage, cleared by reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < S; i++) begin
            entry_q[i] <= rst ? '0 : entry_d[i];
        end
    end

    // Occupancy from registered valid bits, so it trails each change by a cycle
    always_comb begin
        count = '0;
        for (int i = 0; i < S; i++) begin
            count = count + CNT_W'(entry_q[i][VALID_OFF]);
        end
        full = (count == CNT_W'(S));
    end

    assign rd_tuple = entry_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/oram_path_writer.sv
`default_nettype none
// ============================================================================
//  Module      : oram_path_writer
//  Description : Path ORAM write-back engine. Greedily packs stash tuples into
//                each bucket on the path to a target leaf, leaf bucket first,
//                root last. Define ORAM_EVICT_STATS_EN to add the evict_cnt and
//                stash_hwm statistics outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module oram_path_writer
    import oramPkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst,
    oram_path_writer_if.slave   bus
`ifdef ORAM_EVICT_STATS_EN
    ,
    output logic [15:0]         evict_cnt,
    output logic [CNT_W-1:0]    stash_hwm
`endif
);

    wr_state_t             state_q,  state_d;
    logic [POS_W-1:0]      leaf_q,   leaf_d;
    logic [LVL_W-1:0]      level_q,  level_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [FILL_W-1:0]     fill_q,   fill_d;
    logic [BUCKET_W-1:0]   bucket_q, bucket_d;

    logic                  ins_en;
    logic                  rm_en;
    tuple_t                rd_tuple;
    logic [CNT_W-1:0]      count;
    logic                  full;

    oram_stash u_stash (
        .clk       (clk),
        .rst       (rst),
        .ins_en    (ins_en),
        .ins_tuple (bus.in_tuple),
        .rd_idx    (idx_q),
        .rd_tuple  (rd_tuple),
        .rm_en     (rm_en),
        .rm_idx    (idx_q),
        .count     (count),
        .full      (full)
    );

    // Loads only while idle; tuples marked invalid are accepted but not stored
    assign bus.in_ready = (state_q == ST_IDLE) && !full;
    assign ins_en       = bus.in_valid && bus.in_ready && bus.in_tuple[VALID_OFF];

    // Next-state: one stash entry per SCAN cycle, then hold the bucket write
    always_comb begin
        state_d  = state_q;
        leaf_d   = leaf_q;
        level_d  = level_q;
        idx_d    = idx_q;
        fill_d   = fill_q;
        bucket_d = bucket_q;
        rm_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    leaf_d   = bus.leaf;
                    level_d  = LVL_W'(D - 1);
                    idx_d    = '0;
                    fill_d   = '0;
                    bucket_d = '0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (fill_q < FILL_W'(K) && eligible(rd_tuple, leaf_q, level_q)) begin
                    bucket_d[int'(fill_q)*TUPLE_W +: TUPLE_W] = rd_tuple;
                    fill_d = fill_q + 1'b1;
                    rm_en  = 1'b1;
                end
                if (idx_q == IDX_W'(S - 1)) begin
                    state_d = ST_WRITE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (bus.wr_ready) begin
                    if (level_q != '0) begin
                        level_d  = level_q - 1'b1;
                        idx_d    = '0;
                        fill_d   = '0;
                        bucket_d = '0;
                        state_d  = ST_SCAN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and bucket registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            leaf_q   <= '0;
            level_q  <= '0;
            idx_q    <= '0;
            fill_q   <= '0;
            bucket_q <= '0;
        end else begin
            state_q  <= state_d;
            leaf_q   <= leaf_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            fill_q   <= fill_d;
            bucket_q <= bucket_d;
        end
    end

    // Write port is gated by state so address and data read zero when idle
    assign bus.wr_valid    = (state_q == ST_WRITE);
    assign bus.wr_addr     = bus.wr_valid ? (ADDR_W'(node_on_path(leaf_q, level_q)) - ADDR_W'(1))
                                          : '0;
    assign bus.wr_bucket   = bus.wr_valid ? bucket_q : '0;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.stash_count = count;

`ifdef ORAM_EVICT_STATS_EN
    logic [15:0]      evict_cnt_q, evict_cnt_d;
    logic [CNT_W-1:0] stash_hwm_q, stash_hwm_d;

    // Completed-eviction counter and stash occupancy high-water mark
    always_comb begin
        evict_cnt_d = evict_cnt_q + 16'(state_q == ST_DONE);
        stash_hwm_d = (count > stash_hwm_q) ? count : stash_hwm_q;
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            evict_cnt_q <= '0;
            stash_hwm_q <= '0;
        end else begin
            evict_cnt_q <= evict_cnt_d;
            stash_hwm_q <= stash_hwm_d;
        end
    end

    assign evict_cnt = evict_cnt_q;
    assign stash_hwm = stash_hwm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_oram_path_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oram_path_writer
//  Description : Self-checking bench for oram_path_writer with a reference
//                stash/eviction model built from the placement rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_oram_path_writer;
    import oramPkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oram_path_writer_if bus();

`ifdef ORAM_EVICT_STATS_EN
    logic [15:0]      evict_cnt;
    logic [CNT_W-1:0] stash_hwm;
`endif

    oram_path_writer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ORAM_EVICT_STATS_EN
        ,
        .evict_cnt (evict_cnt),
        .stash_hwm (stash_hwm)
`endif
    );

    int     n_vec = 0;
    int     n_err = 0;
    int     m_evicts = 0;
    tuple_t m_t [S];
    bit     m_v [S];

    task automatic chk(input string tag, input logic [BUCKET_W-1:0] obs,
                       input logic [BUCKET_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < S; i++) c += int'(m_v[i]);
        return c;
    endfunction

    function automatic void m_insert(input tuple_t t);
        bit put = 0;
        if (!t[VALID_OFF]) return;
        for (int i = 0; i < S; i++) begin
            if (!put && !m_v[i]) begin
                m_t[i] = t; m_v[i] = 1; put = 1;
            end
        end
    endfunction

    function automatic bit fits(input tuple_t t, input int lf, input int lvl);
        int p;
        if (!t[VALID_OFF]) return 0;
        if (lvl == 0) return 1;
        if (!t[POS_VALID_OFF]) return 0;
        p = int'(t[POS_OFF +: POS_W]);
        return (p % (1 << lvl)) == (lf % (1 << lvl));
    endfunction

    function automatic tuple_t mk(input int pos, input bit pv, input bit v);
        logic [POS_W-1:0] p;
        p = POS_W'(pos);
        return {p, pv, D'($urandom), $urandom, $urandom, 1'($urandom), v};
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_wr_valid"}, bus.wr_valid, 0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 0);
        chk({tag, "_wr_bucket"}, bus.wr_bucket, 0);
        chk({tag, "_stash_count"}, bus.stash_count, 0);
    endtask

    task automatic load(input tuple_t t);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_tuple = t;
        chk("in_ready", bus.in_ready, (m_count() < S));
        if (m_count() < S) m_insert(t);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("stash_count_load", bus.stash_count, m_count());
    endtask

    task automatic run_evict(input int lf, input int stall, input bit with_load,
                             input tuple_t lt);
        logic [BUCKET_W-1:0] exp_b [D];
        int                  exp_a [D];
        logic [BUCKET_W-1:0] held_b;
        logic [ADDR_W-1:0]   held_a;
        int cyc, nw, stalled, node, fill;
        bit seen_done;

        @(negedge clk);
        if (with_load) begin
            bus.in_valid = 1'b1;
            bus.in_tuple = lt;
            if (m_count() < S) m_insert(lt);
        end
        bus.start    = 1'b1;
        bus.leaf     = POS_W'(lf);
        bus.wr_ready = (stall == 0);

        // Reference: bucket contents and address for every level, leaf first
        for (int lvl = D - 1; lvl >= 0; lvl--) begin
            node = 1;
            for (int i = 0; i < lvl; i++) node = node * 2 + ((lf >> i) & 1);
            exp_a[D-1-lvl] = node - 1;
            exp_b[D-1-lvl] = '0;
            fill = 0;
            for (int i = 0; i < S; i++) begin
                if (m_v[i] && fill < K && fits(m_t[i], lf, lvl)) begin
                    exp_b[D-1-lvl][fill*TUPLE_W +: TUPLE_W] = m_t[i];
                    fill++;
                    m_v[i] = 0;
                end
            end
        end
        m_evicts++;

        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        cyc = 1; nw = 0; stalled = 0; seen_done = 0;
        held_a = '0; held_b = '0;
        chk("busy_after_start", bus.busy, 1);

        while (!seen_done && cyc < 300) begin
            if (bus.wr_valid) begin
                if (nw == 0 && stalled < stall) begin
                    bus.wr_ready = 1'b0;
                    if (stalled == 0) begin
                        held_a = bus.wr_addr; held_b = bus.wr_bucket;
                    end else begin
                        chk("stall_addr_stable", bus.wr_addr, held_a);
                        chk("stall_bucket_stable", bus.wr_bucket, held_b);
                    end
                    stalled++;
                end else begin
                    bus.wr_ready = 1'b1;
                    if (nw < D) begin
                        chk("wr_addr", bus.wr_addr, exp_a[nw]);
                        chk("wr_bucket", bus.wr_bucket, exp_b[nw]);
                    end
                    nw++;
                end
            end
            if (bus.done) seen_done = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", seen_done, 1);
        chk("latency", cyc, D * (S + 1) + 1 + stall);
        chk("write_count", nw, D);
        chk("stash_after_evict", bus.stash_count, m_count());
        bus.wr_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("busy_back_idle", bus.busy, 0);
    endtask

    initial begin
        int lf, n;
        bus.in_valid = 1'b0;
        bus.in_tuple = '0;
        bus.start    = 1'b0;
        bus.leaf     = '0;
        bus.wr_ready = 1'b1;
        for (int i = 0; i < S; i++) begin m_v[i] = 0; m_t[i] = '0; end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Empty stash: six all-empty buckets up the leaf-0 path
        run_evict(0, 0, 0, '0);

        // Full-depth match lands at the leaf bucket
        load(mk(5'b10110, 1, 1));
        run_evict(5'b10110, 0, 0, '0);

        // Mismatch at bit 0 only fits the root
        load(mk(5'b00001, 1, 1));
        run_evict(0, 0, 0, '0);

        // Full stash spreads 3/3/2 over the lowest levels; extra load refused
        for (int i = 0; i < S; i++) load(mk(0, 1, 1));
        load(mk(0, 1, 1));
        run_evict(0, 0, 0, '0);

        // Five root-only tuples: three placed, two left behind
        for (int i = 0; i < 5; i++) load(mk(($urandom_range(0, 15) << 1) | 1, 1, 1));
        run_evict(0, 0, 0, '0);
        chk("leftover_count", bus.stash_count, 2);

        // Invalid tuple is accepted and dropped
        load(mk(3, 1, 0));

        // Back-pressure on the first write
        load(mk($urandom_range(0, 31), 1, 1));
        run_evict($urandom_range(0, 31), 4, 0, '0);

        // Load in the same cycle as start joins the eviction
        lf = $urandom_range(0, 31);
        run_evict(lf, 0, 1, mk(lf, 1, 1));

        // Randomised loads and leaves
        repeat (6) begin
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++)
                load(mk($urandom_range(0, 31), ($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 7) != 0)));
            run_evict($urandom_range(0, 31), 0, 0, '0);
        end

`ifdef ORAM_EVICT_STATS_EN
        chk("evict_cnt", evict_cnt, m_evicts);
`endif

        // Reset during SCAN clears everything on the next edge
        for (int i = 0; i < 3; i++) load(mk($urandom_range(0, 31), 1, 1));
        @(negedge clk);
        bus.start = 1'b1;
        bus.leaf  = POS_W'($urandom_range(0, 31));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_in_scan", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_reset");
        rst = 1'b0;
        for (int i = 0; i < S; i++) m_v[i] = 0;
        m_evicts = 0;

        run_evict(0, 0, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oram_path_writer.md
# oram_path_writer

Write-back/eviction engine for the Path ORAM controller, the write-direction counterpart of the path fetch.
- Holds a small stash of tuples and, on `start` with a target leaf, writes every bucket on that root-to-leaf path, leaf first, root last, over a bucket write port.
- Each bucket is filled greedily with stash tuples whose leaf shares a long enough path prefix with the target.
- Tuples that do not fit stay in the stash for the next eviction.

## Interface
Parameters:
- `D`, 6: tree depth. Levels 0 (root) to D-1 (leaves). Leaf position is D-1 bits; block number is D bits.
- `K`, 3: tuples per bucket.
- `A`, 8: bytes per block value.
- `S`, 8: stash entries.

Tuple layout, packed, TUPLE_W = 2*D+8*A+2, MSB to LSB:
- `pos`, D-1 bits
- `pos_valid`, 1 bit
- `b_number`, D bits
- `val`, 8*A bits
- `val_valid`, 1 bit
- `valid`, 1 bit

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  stash load request.
- `in_ready`  out  1  stash can accept this cycle.
- `in_tuple`  in  TUPLE_W  tuple to load.
- `start`  in  1  begin eviction, one-cycle pulse.
- `leaf`  in  D-1  target leaf, sampled with `start`.
- `busy`  out  1  eviction in progress.
- `done`  out  1  one-cycle pulse when the root bucket has been written.
- `wr_valid`  out  1  bucket write request.
- `wr_ready`  in  1  tree memory accepts the write.
- `wr_addr`  out  D+1  bucket index = heap node - 1.
- `wr_bucket`  out  K*TUPLE_W  bucket contents; slot 0 in the LSBs.
- `stash_count`  out  $clog2(S+1)  number of occupied stash entries.

## Operation
- Heap node numbering: root = 1; at level L the node is built from 1 by applying `node = 2*node + leaf[i]` for i = 0..L-1 (LSB first).
- Placement rule: a tuple may sit at level L iff `valid`, `pos_valid`, and `pos[L-1:0] == leaf[L-1:0]`. Level 0 accepts any valid tuple.
- Stash load, IDLE only:
  - `in_ready` = IDLE && stash not full.
  - On handshake, a tuple with `valid`=1 goes into the lowest free entry.
  - A tuple with `valid`=0 is accepted and dropped.
- FSM states:
  - IDLE: on `start`, latch `leaf`, set L = D-1, go to SCAN. `start` with an empty stash still writes D all-empty buckets.
  - SCAN: inspect stash entry 0..S-1, one entry per cycle. An eligible entry fills the next free bucket slot and is removed from the stash. Scanning stops placing once K slots are filled but still takes S cycles. Go to WRITE.
  - WRITE: hold `wr_valid`, `wr_addr`, `wr_bucket` stable until `wr_ready`. Unfilled slots are all-zero.
    - After the handshake, if L > 0: L decrements, bucket clears, go to SCAN.
    - If L = 0: go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. `in_valid` outside IDLE is not accepted.
- `start` and an `in` handshake in the same IDLE cycle: the tuple is stored and included in the eviction.
- Tuples that are never placed remain in the stash.
  - The level-0 scan empties the stash whenever at most K valid tuples remain.
  - Otherwise leftover entries persist.

## Timing
- Reset values: `in_ready`=1, `busy`=0, `done`=0, `wr_valid`=0, `wr_addr`=0, `wr_bucket`=0, `stash_count`=0. The stash is cleared and the FSM is in IDLE.
- Reset mid-eviction: `rst` wins. It takes effect at the next edge, drops `wr_valid` immediately, and loses the stash contents.
- `busy` = 1 from the cycle after `start` through the DONE cycle.
- With `wr_ready` tied high, latency from `start` to `done` is D*(S+1)+1 cycles (D=6, S=8: 55).
- Each wait cycle on `wr_ready` adds one cycle.
- Bucket writes occur in strict order: leaf, then up the path, then root (`wr_addr` = 0).
- `stash_count` updates the cycle after each insert or removal.

## Configuration
- `ORAM_EVICT_STATS_EN` defined: adds output ports
  - `evict_cnt`, 16 bits: completed evictions, wraps.
  - `stash_hwm`, $clog2(S+1) bits: stash high-water mark since reset.
  - Both counters reset to 0.
- Undefined: those ports and their counters do not exist; all other behaviour is identical.

## Structure
- `oramPkg` holds D, K, A, TUPLE_W, the tuple field offsets, and a function `node_on_path(leaf, level)` returning the heap node.
- The eligibility check is also a package function, `eligible(tuple, leaf, level)`, shared with fetch.
- Sub-module `oram_stash`: S-entry storage with lowest-free-index insert, indexed read, indexed remove, `count`, and `full`.

## Test plan
- Reset, then `start` with leaf=0 and an empty stash → six writes to `wr_addr` 31, 15, 7, 3, 1, 0, all-zero buckets; `done` at cycle 55.
- Load one tuple with pos=5'b10110 and leaf=5'b10110 → the tuple lands in slot 0 of `wr_addr` 44 (node 45); every other bucket is empty; `stash_count`=0.
- Load one tuple with pos=5'b00001 and leaf=5'b00000 → it lands at the root (`wr_addr` 0), because the prefix differs at bit 0.
- Load 8 tuples, all with pos=0, and leaf=0 → 3 at the leaf, 3 at level 4, 2 at level 3; `stash_count`=0 at `done`.
- Load 5 tuples with pos differing from leaf at bit 0 → 3 placed at the root, `stash_count`=2.
- Hold `wr_ready` low for 4 cycles on the first write → `wr_*` stay stable and `done` comes 4 cycles later.
- Assert `rst` during SCAN → the next cycle shows the reset values.
